// File: rtl/lector_memoria_debug.sv
// lector_memoria_debug: dumps CELDAS data-memory words as an LSB-first byte stream with valid/ready handshake
//   i_clk, i_reset (async, active high)       clock and reset
//   i_start                                    dump request, sampled only while idle
//   o_Direccion, o_MemRead, i_DatoLeido        read-only port to a memory with 1-cycle registered read
//   o_byte, o_valid, i_ready                   outgoing byte stream
//   o_busy, o_done                             status: not idle, one-cycle end-of-dump pulse
module lector_memoria_debug #(
   parameter int NBITS  = 32,
   parameter int CELDAS = 10
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_start,
   output logic [NBITS-1:0] o_Direccion,
   output logic             o_MemRead,
   input  logic [NBITS-1:0] i_DatoLeido,
   output logic [7:0]       o_byte,
   output logic             o_valid,
   input  logic             i_ready,
   output logic             o_busy,
   output logic             o_done
);
   localparam int NB = NBITS / 8;
   localparam int BW = NB > 1 ? $clog2(NB) : 1;
   localparam int AW = CELDAS > 1 ? $clog2(CELDAS) : 1;
   typedef enum logic [2:0] {IDLE, REQ, WAIT, SEND, DONE} state_t;
   state_t            state;
   logic [AW-1:0]     addr;
   logic [BW-1:0]     byte_cnt;
   logic [NBITS-1:0]  word;
   logic [BW-1:0]     cnt_nx;
   assign cnt_nx = byte_cnt + 1'b1;
   // Every output is a register updated together with the state transition it belongs to.
   always_ff @(posedge i_clk or posedge i_reset)
      if (i_reset) begin
         state       <= IDLE;
         addr        <= '0;
         byte_cnt    <= '0;
         word        <= '0;
         o_Direccion <= '0;
         o_MemRead   <= 1'b0;
         o_byte      <= '0;
         o_valid     <= 1'b0;
         o_busy      <= 1'b0;
         o_done      <= 1'b0;
      end else begin
         o_MemRead <= 1'b0;
         o_done    <= 1'b0;
         case (state)
            IDLE:
               if (i_start) begin
                  addr        <= '0;
                  o_Direccion <= '0;
                  o_MemRead   <= 1'b1;
                  o_busy      <= 1'b1;
                  state       <= REQ;
               end
            REQ: state <= WAIT;
            WAIT: begin
               word     <= i_DatoLeido;
               byte_cnt <= '0;
               o_byte   <= i_DatoLeido[7:0];
               o_valid  <= 1'b1;
               state    <= SEND;
            end
            SEND:
               if (i_ready) begin
                  if (byte_cnt != BW'(NB - 1)) begin
                     byte_cnt <= cnt_nx;
                     o_byte   <= word[{cnt_nx, 3'b000} +: 8];
                  end else begin
                     o_valid <= 1'b0;
                     if (addr == AW'(CELDAS - 1)) begin
                        o_done <= 1'b1;
                        state  <= DONE;
                     end else begin
                        addr        <= addr + 1'b1;
                        o_Direccion <= NBITS'(addr + 1'b1);
                        o_MemRead   <= 1'b1;
                        state       <= REQ;
                     end
                  end
               end
            DONE: begin
               o_busy <= 1'b0;
               state  <= IDLE;
            end
            default: begin
               o_valid <= 1'b0;
               o_busy  <= 1'b0;
               state   <= IDLE;
            end
         endcase
      end
endmodule

// File: tb/tb_lector_memoria_debug.sv
// tb_lector_memoria_debug: table-driven and randomized checks of the memory dump stream, read port and timing
module tb_lector_memoria_debug;
   logic        i_clk = 1'b0;
   logic        i_reset = 1'b1;
   logic        i_start = 1'b0;
   logic        i_ready = 1'b1;
   logic [31:0] i_DatoLeido = '0;
   logic [31:0] o_Direccion;
   logic        o_MemRead;
   logic [7:0]  o_byte;
   logic        o_valid, o_busy, o_done;
   always #5 i_clk = ~i_clk;
   lector_memoria_debug dut (
      .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start),
      .o_Direccion(o_Direccion), .o_MemRead(o_MemRead), .i_DatoLeido(i_DatoLeido),
      .o_byte(o_byte), .o_valid(o_valid), .i_ready(i_ready),
      .o_busy(o_busy), .o_done(o_done)
   );
   logic [31:0] mem [10];
   always @(posedge i_clk)
      if (o_MemRead) i_DatoLeido <= (o_Direccion < 10) ? mem[o_Direccion[3:0]] : 32'hDEAD_BEEF;
   int n_chk = 0, n_fail = 0, cyc = 0, stab_err = 0;
   bit ready_seq [400];
   logic [7:0] got[$], exp_b[$];
   int rd_a[$], rd_c[$], e_rd_a[$], e_rd_c[$], done_c[$], e_done[$], idle_c[$];
   typedef struct {int stall_at; int stall_len; int restart; int exp_done;} vec_t;
   vec_t tv [3];
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask
   // One clock cycle: log what transfers at the coming edge, then observe the next cycle.
   task automatic clk_cycle();
      bit pv;
      logic [7:0] pb;
      pv = o_valid && !i_ready;
      pb = o_byte;
      if (o_valid && i_ready) got.push_back(o_byte);
      @(negedge i_clk);
      cyc++;
      i_ready = ready_seq[cyc < 400 ? cyc : 399];
      if (pv && (!o_valid || o_byte !== pb)) stab_err++;
      if (o_MemRead) begin rd_a.push_back(int'(o_Direccion)); rd_c.push_back(cyc); end
      if (o_done) done_c.push_back(cyc);
      if (!o_busy) idle_c.push_back(cyc);
   endtask
   // Reference: each word costs a request and a wait cycle, then each byte needs one cycle with ready high.
   function automatic void model(input int base);
      int t = base;
      for (int w = 0; w < 10; w++) begin
         e_rd_a.push_back(w);
         e_rd_c.push_back(t + 1);
         t += 2;
         for (int b = 0; b < 4; b++) begin
            t++;
            while (!ready_seq[t] && t < 399) t++;
            exp_b.push_back(8'((mem[w] >> (8 * b)) & 32'hFF));
         end
      end
      e_done.push_back(t + 1);
   endfunction
   function automatic void clear_all();
      got.delete(); exp_b.delete(); rd_a.delete(); rd_c.delete(); e_rd_a.delete();
      e_rd_c.delete(); done_c.delete(); e_done.delete(); idle_c.delete();
      stab_err = 0;
   endfunction
   function automatic void default_mem();
      logic [31:0] d [10] = '{32'h1, 32'hF, 32'h3, 32'h4, 32'h5, 32'h6, 32'h7, 32'h8, 32'h9, 32'hA};
      for (int i = 0; i < 10; i++) mem[i] = d[i];
      for (int i = 0; i < 400; i++) ready_seq[i] = 1'b1;
   endfunction
   task automatic run(input int max_cyc, input bit hold, input int restart);
      @(negedge i_clk);
      cyc = 0;
      i_start = 1'b1;
      i_ready = ready_seq[0];
      while (cyc < max_cyc) begin
         clk_cycle();
         i_start = hold || cyc == restart;
      end
      i_start = 1'b0;
      repeat (3) clk_cycle();
   endtask
   task automatic compare(input string tag);
      check({tag, " n_bytes"}, got.size(), exp_b.size());
      for (int i = 0; i < got.size() && i < exp_b.size(); i++)
         if (got[i] !== exp_b[i] || i % 4 == 0) check($sformatf("%s byte%0d", tag, i), got[i], exp_b[i]);
      check({tag, " n_reads"}, rd_a.size(), e_rd_a.size());
      for (int i = 0; i < rd_a.size() && i < e_rd_a.size(); i++) begin
         check($sformatf("%s rd_addr%0d", tag, i), rd_a[i], e_rd_a[i]);
         check($sformatf("%s rd_cyc%0d", tag, i), rd_c[i], e_rd_c[i]);
      end
      check({tag, " n_done"}, done_c.size(), e_done.size());
      for (int i = 0; i < done_c.size() && i < e_done.size(); i++)
         check($sformatf("%s done_cyc%0d", tag, i), done_c[i], e_done[i]);
      check({tag, " stable"}, stab_err, 0);
   endtask
   initial begin
      tv[0] = '{stall_at: 0, stall_len: 0, restart: -1, exp_done: 61};
      tv[1] = '{stall_at: 9, stall_len: 5, restart: -1, exp_done: 66};
      tv[2] = '{stall_at: 0, stall_len: 0, restart: 20, exp_done: 61};
      default_mem();
      repeat (2) @(negedge i_clk);
      check("rst o_Direccion", o_Direccion, 0);
      check("rst o_MemRead", o_MemRead, 0);
      check("rst o_byte", o_byte, 0);
      check("rst o_valid", o_valid, 0);
      check("rst o_busy", o_busy, 0);
      check("rst o_done", o_done, 0);
      i_reset = 1'b0;
      repeat (2) @(negedge i_clk);
      for (int v = 0; v < 3; v++) begin
         default_mem();
         for (int c = tv[v].stall_at; c < tv[v].stall_at + tv[v].stall_len; c++) ready_seq[c] = 1'b0;
         clear_all();
         model(0);
         run(80, 1'b0, tv[v].restart);
         compare($sformatf("vec%0d", v));
         check($sformatf("vec%0d done_tab", v), done_c.size() > 0 ? done_c[0] : -1, tv[v].exp_done);
      end
      default_mem();
      clear_all();
      model(0);
      model(62);
      run(123, 1'b1, -1);
      compare("hold");
      check("hold idle_first", idle_c.size() > 0 ? idle_c[0] : -1, 62);
      check("hold idle_between", (idle_c.size() > 1) ? idle_c[1] : -1, 124);
      default_mem();
      clear_all();
      @(negedge i_clk);
      cyc = 0;
      i_start = 1'b1;
      clk_cycle();
      i_start = 1'b0;
      while (cyc < 28) clk_cycle();
      check("pre_reset o_valid", o_valid, 1);
      #2 i_reset = 1'b1;
      #1;
      check("async o_valid", o_valid, 0);
      check("async o_busy", o_busy, 0);
      check("async o_Direccion", o_Direccion, 0);
      check("async o_MemRead", o_MemRead, 0);
      check("async o_byte", o_byte, 0);
      @(negedge i_clk);
      i_reset = 1'b0;
      repeat (70) clk_cycle();
      check("abort n_done", done_c.size(), 0);
      check("abort o_busy", o_busy, 0);
      clear_all();
      model(0);
      run(70, 1'b0, -1);
      compare("after_reset");
      for (int r = 0; r < 4; r++) begin
         for (int i = 0; i < 10; i++) mem[i] = $urandom;
         for (int i = 0; i < 400; i++) ready_seq[i] = $urandom_range(0, 3) != 0;
         clear_all();
         model(0);
         run(e_done[0] + 2, 1'b0, -1);
         compare($sformatf("rand%0d", r));
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/lector_memoria_debug.md
LECTOR_MEMORIA_DEBUG -- requirements
Module: lector_memoria_debug

Interface
REQ-001 Parameter NBITS, default 32, data-memory word and address width; SHALL be a multiple of 8.
REQ-002 Parameter CELDAS, default 10, number of data-memory words dumped per run.
REQ-003 i_clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 i_reset  input  1  asynchronous, active-high reset.
REQ-005 i_start  input  1  dump request; sampled only in IDLE.
REQ-006 o_Direccion  output  NBITS  word address driven to the data memory's read-address port.
REQ-007 o_MemRead  output  1  read strobe to the data memory.
REQ-008 i_DatoLeido  input  NBITS  registered memory read data; valid the cycle after o_MemRead is high.
REQ-009 o_byte  output  8  outgoing byte, for example to the debug UART TX.
REQ-010 o_valid  output  1  o_byte is valid.
REQ-011 i_ready  input  1  sink accepts o_byte.
REQ-012 o_busy  output  1  high in every state except IDLE.
REQ-013 o_done  output  1  one-cycle pulse at the end of a complete dump.

Function
REQ-014 The FSM SHALL have the states IDLE, REQ, WAIT, SEND and DONE.
REQ-015 IDLE: o_MemRead=0 and o_valid=0; if i_start=1, the FSM SHALL clear addr to 0 and go to REQ.
REQ-016 REQ: for exactly one cycle the block SHALL drive o_MemRead=1 and o_Direccion=addr, then go to WAIT.
REQ-017 WAIT: o_MemRead=0; at the closing edge the block SHALL capture i_DatoLeido into a word register, clear byte_cnt and go to SEND.
REQ-018 SEND: o_valid=1 and o_byte=word[8*byte_cnt +: 8]; bytes SHALL be sent LSB first.
REQ-019 A byte SHALL transfer on an edge where o_valid and i_ready are both 1; o_byte SHALL stay stable while o_valid=1 and i_ready=0.
REQ-020 On a transfer with byte_cnt < NBITS/8-1, the block SHALL increment byte_cnt.
REQ-021 On a transfer of the last byte:
- if addr = CELDAS-1, go to DONE;
- otherwise, increment addr and go to REQ.
REQ-022 DONE: o_done=1 for exactly one cycle, then go to IDLE.
REQ-023 addr SHALL never exceed CELDAS-1; it SHALL be zero-extended onto o_Direccion.
REQ-024 The block SHALL ignore i_start in every state other than IDLE, with no queuing.
REQ-025 While o_MemRead=0, o_Direccion SHALL hold its last value.
REQ-026 The block SHALL never issue a write to the data memory.
REQ-027 Throughput with i_ready held at 1:
- 2 + NBITS/8 cycles per word;
- o_done SHALL assert exactly CELDAS*(2+NBITS/8)+1 cycles after the edge that accepts i_start (61 cycles at the defaults).
REQ-028 If i_start=1 in the DONE cycle, the block SHALL ignore it; a new dump requires i_start=1 while in IDLE.

Reset
REQ-029 While i_reset=1, regardless of clock, the block SHALL immediately:
- enter IDLE;
- clear addr, byte_cnt and the word register;
- drive o_Direccion=0, o_MemRead=0, o_byte=0, o_valid=0, o_busy=0, o_done=0.
REQ-030 A reset in any state SHALL abort the dump with no o_done pulse; the next dump SHALL restart from address 0.

Verification
REQ-031 Memory model: 1-cycle registered read, words 0..9 = 0x1, 0xF, 0x3, 0x4, 0x5, 0x6, 0x7, 0x8, 0x9, 0xA; i_ready=1; pulse i_start -> byte stream 01 00 00 00 0F 00 00 00 03 00 00 00 ... 0A 00 00 00 (40 bytes), o_done exactly 61 cycles after start.
REQ-032 Same run, monitor the memory port -> exactly 10 one-cycle o_MemRead pulses at o_Direccion 0,1,...,9 in order, each 6 cycles apart.
REQ-033 Backpressure: i_ready=0 for 5 cycles while byte 0 of word 1 is presented -> o_valid stays 1, o_byte holds 0x0F, no byte lost or duplicated, o_done delayed by exactly 5 cycles (66).
REQ-034 Pulse i_start again at cycle 20 of a dump -> ignored; stream and o_done timing identical to REQ-031.
REQ-035 Assert i_reset during SEND of word 4 -> o_valid=0, o_busy=0, o_Direccion=0 immediately, no o_done; next i_start -> full dump from address 0 matching REQ-031.
REQ-036 Default parameters, i_start held at 1 continuously -> back-to-back dumps, each producing the REQ-031 stream, with one o_done pulse per dump and one IDLE cycle between dumps.
